// File: rtl/iic_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : iic_master_if
//  Purpose  : Command/response handshake between a bus-register front end
//             and the iic_master byte engine.
//  Revision : 1.0  initial release
// ============================================================================
interface iic_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] wr_data;
    logic       nack_in;
    logic       rsp_valid;
    logic [7:0] rd_data;
    logic       ack_out;
    logic       busy;

    // Front end issuing commands
    modport master (
        output cmd_valid, cmd, wr_data, nack_in,
        input  cmd_ready, rsp_valid, rd_data, ack_out, busy
    );

    // Engine executing commands
    modport slave (
        input  cmd_valid, cmd, wr_data, nack_in,
        output cmd_ready, rsp_valid, rd_data, ack_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/iic_master.sv
`default_nettype none
// ============================================================================
//  Module   : iic_master
//  Purpose  : Byte-level single-master I2C engine. Executes START, STOP,
//             WRITE and READ commands as sequences of quarter-period phases,
//             honours slave clock stretching and drives open-drain pads
//             through active-low release controls.
//  Revision : 1.0  initial release
// ============================================================================
module iic_master #(
    parameter int DIV  = 125,
    parameter int CNTW = 16
) (
    input  wire          bus_clk,
    input  wire          reset_l,
    iic_master_if.slave  cmd_if,
    input  wire          scl_in,
    input  wire          sda_in,
    output logic         scl_drive_l,
    output logic         sda_drive_l
);

    localparam logic [1:0]      c_CMD_START = 2'b00;
    localparam logic [1:0]      c_CMD_STOP  = 2'b01;
    localparam logic [1:0]      c_CMD_WRITE = 2'b10;
    localparam logic [1:0]      c_CMD_READ  = 2'b11;
    localparam logic [0:0]      c_IDLE      = 1'b0;
    localparam logic [0:0]      c_RUN       = 1'b1;
    localparam logic [CNTW-1:0] c_CNT_LAST  = CNTW'(DIV - 1);

    logic [0:0]      state_q,    state_d;
    logic [1:0]      phase_q,    phase_d;
    logic [3:0]      bit_q,      bit_d;
    logic [CNTW-1:0] cnt_q,      cnt_d;
    logic [1:0]      cmd_q,      cmd_d;
    logic [7:0]      tx_q,       tx_d;
    logic            nack_q,     nack_d;
    logic [8:0]      rx_q,       rx_d;
    logic [7:0]      rd_data_q,  rd_data_d;
    logic            ack_q,      ack_d;
    logic            rsp_q,      rsp_d;
    logic            scl_drv_q,  scl_drv_d;
    logic            sda_drv_q,  sda_drv_d;
    logic [1:0]      rel_age_q,  rel_age_d;
    logic [1:0]      scl_sync_q, scl_sync_d;
    logic [1:0]      sda_sync_q, sda_sync_d;
    logic            w_stall;
    logic            w_slot_sda;

    // Next-state: synchronizers, phase sequencing, sampling and pad drive
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        tx_d       = tx_q;
        nack_d     = nack_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        ack_d      = ack_q;
        rsp_d      = 1'b0;
        scl_sync_d = {scl_sync_q[0], scl_in};
        sda_sync_d = {sda_sync_q[0], sda_in};

        // Cycles since SCL was released, saturating at the synchronizer
        // depth; before that the synced copy still shows our own low drive.
        if (!scl_drv_q) begin
            rel_age_d = 2'd0;
        end else if (rel_age_q == 2'd2) begin
            rel_age_d = 2'd2;
        end else begin
            rel_age_d = rel_age_q + 2'd1;
        end

        // Released SCL still seen low once the sync has caught up: a slave
        // is stretching, so the quarter counter holds.
        w_stall = scl_drv_q && (rel_age_q == 2'd2) && !scl_sync_q[1];

        case (state_q)
            c_IDLE: begin
                if (cmd_if.cmd_valid) begin
                    state_d = c_RUN;
                    phase_d = 2'd0;
                    bit_d   = 4'd0;
                    cnt_d   = '0;
                    cmd_d   = cmd_if.cmd;
                    tx_d    = cmd_if.wr_data;
                    nack_d  = cmd_if.nack_in;
                end
            end
            c_RUN: begin
                if (!w_stall) begin
                    if (cnt_q == c_CNT_LAST) begin
                        cnt_d = '0;
                        if (phase_q == 2'd2 && cmd_q[1]) begin
                            rx_d = {rx_q[7:0], sda_sync_q[1]};
                        end
                        if (phase_q != 2'd3) begin
                            phase_d = phase_q + 2'd1;
                        end else if (cmd_q[1] && bit_q != 4'd8) begin
                            bit_d   = bit_q + 4'd1;
                            phase_d = 2'd0;
                        end else begin
                            state_d = c_IDLE;
                            rsp_d   = 1'b1;
                            if (cmd_q == c_CMD_WRITE) begin
                                ack_d = ~rx_q[0];
                            end
                            if (cmd_q == c_CMD_READ) begin
                                rd_data_d = rx_q[8:1];
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            default: state_d = c_IDLE;
        endcase

        // SDA level for the upcoming bit slot; slot 8 is the ACK slot.
        if (cmd_d == c_CMD_WRITE) begin
            w_slot_sda = (bit_d == 4'd8) ? 1'b1 : tx_d[~bit_d[2:0]];
        end else begin
            w_slot_sda = (bit_d == 4'd8) ? nack_d : 1'b1;
        end

        // Pad drive for the phase being entered; idle keeps the last levels.
        scl_drv_d = scl_drv_q;
        sda_drv_d = sda_drv_q;
        if (state_d == c_RUN) begin
            case (cmd_d)
                c_CMD_START: begin
                    case (phase_d)
                        2'd0:    sda_drv_d = 1'b1;
                        2'd1:    begin scl_drv_d = 1'b1; sda_drv_d = 1'b1; end
                        2'd2:    begin scl_drv_d = 1'b1; sda_drv_d = 1'b0; end
                        default: begin scl_drv_d = 1'b0; sda_drv_d = 1'b0; end
                    endcase
                end
                c_CMD_STOP: begin
                    case (phase_d)
                        2'd0:    sda_drv_d = 1'b0;
                        2'd1:    begin scl_drv_d = 1'b1; sda_drv_d = 1'b0; end
                        default: begin scl_drv_d = 1'b1; sda_drv_d = 1'b1; end
                    endcase
                end
                default: begin
                    sda_drv_d = w_slot_sda;
                    scl_drv_d = (phase_d == 2'd1) || (phase_d == 2'd2);
                end
            endcase
        end
    end

    // State registers; reset releases both pads at once
    always_ff @(posedge bus_clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= c_IDLE;
            phase_q    <= 2'd0;
            bit_q      <= 4'd0;
            cnt_q      <= '0;
            cmd_q      <= 2'b00;
            tx_q       <= 8'h00;
            nack_q     <= 1'b0;
            rx_q       <= 9'h000;
            rd_data_q  <= 8'h00;
            ack_q      <= 1'b0;
            rsp_q      <= 1'b0;
            scl_drv_q  <= 1'b1;
            sda_drv_q  <= 1'b1;
            rel_age_q  <= 2'd0;
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            tx_q       <= tx_d;
            nack_q     <= nack_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            ack_q      <= ack_d;
            rsp_q      <= rsp_d;
            scl_drv_q  <= scl_drv_d;
            sda_drv_q  <= sda_drv_d;
            rel_age_q  <= rel_age_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

    assign cmd_if.cmd_ready = (state_q == c_IDLE);
    assign cmd_if.busy      = (state_q != c_IDLE);
    assign cmd_if.rsp_valid = rsp_q;
    assign cmd_if.rd_data   = rd_data_q;
    assign cmd_if.ack_out   = ack_q;
    assign scl_drive_l      = scl_drv_q;
    assign sda_drive_l      = sda_drv_q;

endmodule
`default_nettype wire

// File: tb/tb_iic_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iic_master
//  Purpose  : Directed self-checking bench for iic_master (DIV = 4) with an
//             open-drain bus, pull-ups and a small I2C slave model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iic_master;

    localparam int c_DIV = 4;

    logic bus_clk = 1'b0;
    logic reset_l = 1'b0;
    logic scl_drive_l, sda_drive_l;
    logic scl_pad, sda_pad;

    int n_checks = 0;
    int n_errors = 0;

    // Slave model state
    logic       slv_sda_low = 1'b0;
    logic       slv_scl_low = 1'b0;
    int         slv_mode    = 0;      // 0 silent, 1 ACK a write, 2 return slv_byte
    logic [7:0] slv_byte    = 8'h00;
    int         str_slot    = -1;     // bit slot in which SCL is stretched
    int         arm_req     = 0;
    int         arm_seen    = 0;
    int         slv_cnt     = 0;
    int         str_armed   = -1;
    int         hold        = 0;
    logic       scl_prev    = 1'b1;
    logic [8:0] rec         = 9'h000; // SDA seen at each SCL rise

    logic scl_tr [0:1023];
    logic sda_tr [0:1023];

    iic_master_if cmd_if ();

    iic_master #(.DIV(c_DIV), .CNTW(16)) u_dut (
        .bus_clk     (bus_clk),
        .reset_l     (reset_l),
        .cmd_if      (cmd_if),
        .scl_in      (scl_pad),
        .sda_in      (sda_pad),
        .scl_drive_l (scl_drive_l),
        .sda_drive_l (sda_drive_l)
    );

    // Wired-AND bus with pull-ups
    assign scl_pad = scl_drive_l & ~slv_scl_low;
    assign sda_pad = sda_drive_l & ~slv_sda_low;

    always #5 bus_clk = ~bus_clk;

    function automatic logic slot_drive(input int k);
        if (slv_mode == 1) return (k == 8);
        if (slv_mode == 2 && k < 8) return ~slv_byte[7 - k];
        return 1'b0;
    endfunction

    // Slave: acts on the falling clock edge, away from the DUT's sampling edge
    always @(negedge bus_clk) begin
        logic cur;
        cur      = scl_pad;
        if (arm_req != arm_seen) begin
            arm_seen    = arm_req;
            slv_cnt     = 0;
            rec         = 9'h000;
            str_armed   = str_slot;
            slv_sda_low = slot_drive(0);
        end else begin
            if (cur && !scl_prev) rec = {rec[7:0], sda_pad};
            if (!cur && scl_prev) begin
                slv_cnt++;
                slv_sda_low = slot_drive(slv_cnt);
                if (slv_cnt == str_armed) begin
                    slv_scl_low = 1'b1;
                    hold        = 0;
                    str_armed   = -1;
                end
            end
            if (slv_scl_low && scl_drive_l) begin
                hold++;
                if (hold == 51) slv_scl_low = 1'b0;
            end
        end
        scl_prev = cur;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input int mode, input logic [7:0] b, input int sslot);
        slv_mode = mode;
        slv_byte = b;
        str_slot = sslot;
        arm_req++;
        repeat (2) @(negedge bus_clk);
    endtask

    // Issue one command, trace the pads (index n = cycles after accept),
    // return cycles from accept+1 to rsp_valid.
    task automatic run_cmd(input logic [1:0] c, input logic [7:0] wd, input logic nk,
                           output int lat);
        int n;
        bit done;
        @(negedge bus_clk);
        chk("ready_before", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = c;
        cmd_if.wr_data   = wd;
        cmd_if.nack_in   = nk;
        n    = 0;
        done = 0;
        lat  = -1;
        while (!done && n < 1000) begin
            @(negedge bus_clk);
            n++;
            if (n == 1) begin
                cmd_if.cmd_valid = 1'b0;
                cmd_if.wr_data   = ~wd;
                cmd_if.nack_in   = ~nk;
                chk("ready_drop", cmd_if.cmd_ready, 0);
                chk("busy", cmd_if.busy, 1);
            end
            scl_tr[n] = scl_pad;
            sda_tr[n] = sda_pad;
            if (cmd_if.rsp_valid) begin
                done = 1;
                lat  = n - 1;
                chk("ready_at_rsp", cmd_if.cmd_ready, 1);
            end
        end
        chk("rsp_seen", done, 1);
        @(negedge bus_clk);
        chk("rsp_one_cycle", cmd_if.rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd       = 2'b00;
        cmd_if.wr_data   = 8'h00;
        cmd_if.nack_in   = 1'b0;
        repeat (3) @(negedge bus_clk);
        chk("rst_scl", scl_drive_l, 1);
        chk("rst_sda", sda_drive_l, 1);
        chk("rst_ready", cmd_if.cmd_ready, 1);
        chk("rst_rsp", cmd_if.rsp_valid, 0);
        reset_l = 1'b1;
        repeat (2) @(negedge bus_clk);
        chk("idle_busy", cmd_if.busy, 0);
        chk("idle_rd", cmd_if.rd_data, 8'h00);
        chk("idle_ack", cmd_if.ack_out, 0);

        // START then STOP
        run_cmd(2'b00, 8'h00, 1'b0, lat);
        chk("start_lat", lat, 16);
        chk("start_sda_hi", sda_tr[8], 1);
        chk("start_sda_fall", sda_tr[9], 0);
        chk("start_scl_hi_at_fall", scl_tr[9], 1);
        chk("start_scl_hi_p2", scl_tr[12], 1);
        chk("start_scl_low", scl_tr[16], 0);
        run_cmd(2'b01, 8'h00, 1'b0, lat);
        chk("stop_lat", lat, 16);
        chk("stop_sda_low", sda_tr[8], 0);
        chk("stop_sda_rise", sda_tr[9], 1);
        chk("stop_scl_hi", scl_tr[9], 1);
        chk("stop_scl_rel", scl_drive_l, 1);
        chk("stop_sda_rel", sda_drive_l, 1);

        // WRITE 0xA5, slave ACKs
        run_cmd(2'b00, 8'h00, 1'b0, lat);
        arm(1, 8'h00, -1);
        run_cmd(2'b10, 8'hA5, 1'b0, lat);
        chk("wr_a5_lat", lat, 144);
        chk("wr_a5_bits", rec, {8'hA5, 1'b0});
        chk("wr_a5_ack", cmd_if.ack_out, 1);

        // WRITE 0x3C, nobody answers
        arm(0, 8'h00, -1);
        run_cmd(2'b10, 8'h3C, 1'b0, lat);
        chk("wr_3c_bits", rec, {8'h3C, 1'b1});
        chk("wr_3c_ack", cmd_if.ack_out, 0);
        chk("wr_3c_rd_kept", cmd_if.rd_data, 8'h00);

        // READ with NACK, then READ with ACK
        arm(2, 8'h5A, -1);
        run_cmd(2'b11, 8'h00, 1'b1, lat);
        chk("rd_5a_lat", lat, 144);
        chk("rd_5a_data", cmd_if.rd_data, 8'h5A);
        chk("rd_5a_nack_bus", rec, {8'h5A, 1'b1});
        chk("rd_ack_kept", cmd_if.ack_out, 0);
        arm(2, 8'hC3, -1);
        run_cmd(2'b11, 8'h00, 1'b0, lat);
        chk("rd_c3_data", cmd_if.rd_data, 8'hC3);
        chk("rd_c3_ack_bus", rec, {8'hC3, 1'b0});

        // WRITE with SCL held low 50 cycles past release in slot 3.
        // Pad stays low until mid cycle R+50 (R = release cycle), the sync
        // sees it high at R+52, so the counter holds for R+2..R+51.
        arm(1, 8'h00, 3);
        run_cmd(2'b10, 8'h96, 1'b0, lat);
        chk("str_lat", lat, 144 + 50);
        chk("str_bits", rec, {8'h96, 1'b0});
        chk("str_ack", cmd_if.ack_out, 1);
        chk("str_rd_kept", cmd_if.rd_data, 8'hC3);
        run_cmd(2'b01, 8'h00, 1'b0, lat);
        chk("stop2_lat", lat, 16);

        // Reset in the middle of a READ
        run_cmd(2'b00, 8'h00, 1'b0, lat);
        arm(0, 8'h00, -1);
        @(negedge bus_clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = 2'b11;
        cmd_if.nack_in   = 1'b1;
        @(negedge bus_clk);
        cmd_if.cmd_valid = 1'b0;
        repeat (40) @(negedge bus_clk);
        chk("mid_busy", cmd_if.busy, 1);
        #2 reset_l = 1'b0;
        #1;
        chk("arst_scl", scl_drive_l, 1);
        chk("arst_sda", sda_drive_l, 1);
        chk("arst_ready", cmd_if.cmd_ready, 1);
        chk("arst_rd", cmd_if.rd_data, 8'h00);
        chk("arst_ack", cmd_if.ack_out, 0);
        repeat (2) @(negedge bus_clk);
        reset_l = 1'b1;
        repeat (2) @(negedge bus_clk);
        run_cmd(2'b00, 8'h00, 1'b0, lat);
        chk("re_start_lat", lat, 16);
        chk("re_start_sda_fall", sda_tr[9], 0);
        chk("re_start_scl_hi", scl_tr[9], 1);
        chk("re_start_scl_low", scl_tr[16], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
